// File: rtl/cordic_hyperbolic_vectoring_32bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_hyperbolic_vectoring_32bit                            |
// | Description : Iterative hyperbolic-vectoring CORDIC computing atanh(y/x)   |
// |               and sqrt(x^2-y^2). Optional macro CORDIC_GAIN_COMP_EN adds   |
// |               a gain-compensation state for the magnitude output.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_hyperbolic_vectoring_32bit #(
    parameter int LEN  = 32,
    parameter int FRAC = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LEN-1:0] x_in,
    input  logic [LEN-1:0] y_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] angle,
    output logic [LEN-1:0] mag,
    output logic           range_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] c_ST_COMP = 2'd2;
    localparam logic signed [2*LEN-1:0] c_INV_KH = (2*LEN)'(32'h0001351E);
`endif
    localparam logic [1:0] c_ST_DONE = 2'd3;
    localparam logic [4:0] c_LAST    = 5'd18;
    localparam int unsigned c_TAB_UP = (FRAC > 16) ? FRAC - 16 : 0;
    localparam int unsigned c_TAB_DN = (FRAC < 16) ? 16 - FRAC : 0;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [4:0]            r_cnt;
    logic [4:0]            w_shift;
    logic signed [LEN-1:0] r_x, r_y, r_z;
    logic signed [LEN-1:0] w_xs, w_ys, w_tab, w_xn, w_yn, w_zn, w_mag_final;
    logic signed [LEN:0]   w_xext, w_yext, w_absy;
    logic                  w_in_err;
    logic                  r_err;
    logic [LEN-1:0]        r_angle, r_mag;
    logic                  r_range_err;

    // Table held in Q16 and rescaled to the configured fraction width.
    function automatic logic signed [LEN-1:0] atanh_tab(input logic [4:0] i);
        logic signed [LEN-1:0] v;
        case (i)
            5'd1:    v = LEN'(35999);
            5'd2:    v = LEN'(16739);
            5'd3:    v = LEN'(8235);
            5'd4:    v = LEN'(4101);
            5'd5:    v = LEN'(2049);
            5'd6:    v = LEN'(1024);
            5'd7:    v = LEN'(512);
            5'd8:    v = LEN'(256);
            5'd9:    v = LEN'(128);
            5'd10:   v = LEN'(64);
            5'd11:   v = LEN'(32);
            5'd12:   v = LEN'(16);
            5'd13:   v = LEN'(8);
            5'd14:   v = LEN'(4);
            5'd15:   v = LEN'(2);
            5'd16:   v = LEN'(1);
            default: v = '0;
        endcase
        return (v <<< c_TAB_UP) >>> c_TAB_DN;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid) w_next = c_ST_RUN;
`ifdef CORDIC_GAIN_COMP_EN
            c_ST_RUN:  if (r_cnt == c_LAST) w_next = c_ST_COMP;
            c_ST_COMP: w_next = c_ST_DONE;
`else
            c_ST_RUN:  if (r_cnt == c_LAST) w_next = c_ST_DONE;
`endif
            c_ST_DONE: if (out_ready) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
    end

    // Steps 0..17 walk shift 1..16 with shifts 4 and 13 repeated.
    always_comb begin
        if (r_cnt <= 5'd3)       w_shift = r_cnt + 5'd1;
        else if (r_cnt <= 5'd13) w_shift = r_cnt;
        else                     w_shift = r_cnt - 5'd1;
    end

    always_comb begin
        w_xs  = r_x >>> w_shift;
        w_ys  = r_y >>> w_shift;
        w_tab = atanh_tab(w_shift);
        if (r_y[LEN-1]) begin
            w_xn = r_x + w_ys;
            w_yn = r_y + w_xs;
            w_zn = r_z - w_tab;
        end else begin
            w_xn = r_x - w_ys;
            w_yn = r_y - w_xs;
            w_zn = r_z + w_tab;
        end
    end

    always_comb begin
        w_xext   = {x_in[LEN-1], x_in};
        w_yext   = {y_in[LEN-1], y_in};
        w_absy   = w_yext[LEN] ? -w_yext : w_yext;
        w_in_err = (w_xext <= 0) || (w_absy >= w_xext);
    end

`ifdef CORDIC_GAIN_COMP_EN
    always_comb w_mag_final = LEN'(({{LEN{r_x[LEN-1]}}, r_x} * c_INV_KH) >>> FRAC);
`else
    always_comb w_mag_final = r_x;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (in_valid) begin
                r_x   <= x_in;
                r_y   <= y_in;
                r_z   <= '0;
                r_cnt <= '0;
                r_err <= w_in_err;
            end
        end else if (r_state == c_ST_RUN && r_cnt != c_LAST) begin
            r_x   <= w_xn;
            r_y   <= w_yn;
            r_z   <= w_zn;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Results are captured only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle     <= '0;
            r_mag       <= '0;
            r_range_err <= 1'b0;
        end else if (w_next == c_ST_DONE && r_state != c_ST_DONE) begin
            r_angle     <= r_err ? '0 : r_z;
            r_mag       <= r_err ? '0 : w_mag_final;
            r_range_err <= r_err;
        end
    end

    assign angle     = r_angle;
    assign mag       = r_mag;
    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_cordic_hyperbolic_vectoring_32bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cordic_hyperbolic_vectoring_32bit                         |
// | Description : Directed, table-driven self-checking bench for the CORDIC.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cordic_hyperbolic_vectoring_32bit;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int c_LAT = 20;
    localparam logic [31:0] c_MAG_SQ3 = 32'h0001BB67;
    localparam logic [31:0] c_MAG_ONE = 32'h00010000;
    localparam logic [31:0] c_MAG_Q75 = 32'h0000DDB4;
`else
    localparam int c_LAT = 19;
    localparam logic [31:0] c_MAG_SQ3 = 32'h00016F36;
    localparam logic [31:0] c_MAG_ONE = 32'h0000D403;
    localparam logic [31:0] c_MAG_Q75 = 32'h0000B79B;
`endif

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, range_err;
    logic [31:0] x_in, y_in, angle, mag;

    cordic_hyperbolic_vectoring_32bit #(.LEN(32), .FRAC(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle(angle), .mag(mag), .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] x, y, ea, em;
        int          ta, tm;
        logic        ee;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        int d;
        d = $signed(act - exp);
        checks++;
        if (d > tol || d < -tol) begin
            errs++;
            $display("FAIL %s: got %h want %h (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Launch one operation; lat counts edges from acceptance to out_valid.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        in_valid = 1'b1; x_in = x; y_in = y;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        int          lat;
        logic [31:0] ha, hm;
        logic        stable;
        real         r, ar;
        int          ea;

        vecs[0] = '{32'h00020000, 32'h00010000, 32'h00008C9F, c_MAG_SQ3, 4, 8, 1'b0};
        vecs[1] = '{32'h00010000, 32'h00000000, 32'h00000000, c_MAG_ONE, 2, 8, 1'b0};
        vecs[2] = '{32'h00010000, 32'hFFFF8000, 32'hFFFF7361, c_MAG_Q75, 4, 8, 1'b0};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'h0,        32'h0,     0, 0, 1'b1};
        vecs[4] = '{32'hFFFF0000, 32'h00000000, 32'h0,        32'h0,     0, 0, 1'b1};
        vecs[5] = '{32'h00000000, 32'h00000000, 32'h0,        32'h0,     0, 0, 1'b1};
        vecs[6] = '{32'h00010000, 32'hFFFF0000, 32'h0,        32'h0,     0, 0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
        chk("rst_angle",     angle,              32'd0, 0);
        chk("rst_mag",       mag,                32'd0, 0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].x, vecs[i].y, lat);
            chk($sformatf("v%0d_latency", i), lat, c_LAT, 0);
            chk($sformatf("v%0d_angle", i), angle, vecs[i].ea, vecs[i].ta);
            chk($sformatf("v%0d_mag", i), mag, vecs[i].em, vecs[i].tm);
            chk($sformatf("v%0d_range_err", i), {31'd0, range_err}, {31'd0, vecs[i].ee}, 0);
            release_result();
        end

        // Hold the result with out_ready low for ten cycles.
        do_op(32'h00020000, 32'h00010000, lat);
        chk("hold_angle", angle, 32'h00008C9F, 4);
        ha = angle; hm = mag; stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!out_valid || in_ready || angle !== ha || mag !== hm) stable = 1'b0;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1, 0);
        release_result();
        chk("idle_keeps_angle", angle, 32'h00008C9F, 4);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1; x_in = 32'h00020000; y_in = 32'h00010000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0, 0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1, 0);
        chk("midrst_angle",     angle,              32'd0, 0);
        chk("midrst_mag",       mag,                32'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h00020000, 32'hFFFF0000, lat);
        chk("postrst_latency", lat, c_LAT, 0);
        chk("postrst_angle", angle, 32'hFFFF7361, 4);
        chk("postrst_mag", mag, c_MAG_SQ3, 8);
        chk("postrst_range_err", {31'd0, range_err}, 32'd0, 0);
        release_result();

        // Sweep against a floating-point atanh model.
        for (int k = -12; k <= 12; k++) begin
            do_op(32'h00010000, k * 32'sh1000, lat);
            r  = real'(k) * 4096.0 / 65536.0;
            ar = 0.5 * $ln((1.0 + r) / (1.0 - r)) * 65536.0;
            ea = int'(ar);
            chk($sformatf("sweep_angle_y%0d", k), angle, ea, 8);
            release_result();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
